apb_req_arbiter: RTL and testbench

Multi-requester APB master that shares the single APB slave (16 x 8-bit register memory) among NUM_REQ on-chip clients.
- Arbitrates requests round-robin and sequences the APB SETUP/ACCESS phases.
- Returns read data and error status to the winning requester.
- Sits directly upstream of the APB slave, driving its psel/penable/pwrite/paddr/pwdata inputs.

---
 rtl/apb_ctrl_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 47 ++++
 rtl/apb_req_arbiter.sv | 143 ++++++++++++++
 tb/tb_apb_req_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_ctrl_pkg.sv
// Shared types and default geometry for the multi-requester APB master.
package apb_ctrl_pkg;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_MEM_DEPTH  = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: picks the first requesting index at or after the pointer,
// wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_valid
);

    int w_best;
    int w_bestDist;
    int w_dist;

    // Rotational distance from the pointer; the smallest distance among active requests wins.
    always_comb begin
        w_best     = 0;
        w_bestDist = NUM_REQ;
        w_dist     = 0;
        for (int j = 0; j < NUM_REQ; j++) begin
            w_dist = j - int'(i_ptr);
            if (w_dist < 0) begin
                w_dist = w_dist + NUM_REQ;
            end
            if (i_req[j] && (w_dist < w_bestDist)) begin
                w_bestDist = w_dist;
                w_best     = j;
            end
        end
    end

    assign o_valid = |i_req;
    assign o_idx   = IDX_W'(w_best);

    always_comb begin
        o_grant = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (o_valid && (w_best == j)) begin
                o_grant[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// APB master shared by NUM_REQ clients: round-robin arbitration, SETUP/ACCESS
// sequencing with a wait-state timeout, and a one-cycle response to the winner.
module apb_req_arbiter
    import apb_ctrl_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int WIDTH      = DEF_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int TIMEOUT    = 15
) (
    input  logic                         pclk_i,
    input  logic                         preset_i,
    input  logic [NUM_REQ-1:0]           req_valid_i,
    input  logic [NUM_REQ-1:0]           req_write_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NUM_REQ*WIDTH-1:0]     req_wdata_i,
    output logic [NUM_REQ-1:0]           req_ready_o,
    output logic [NUM_REQ-1:0]           rsp_valid_o,
    output logic [WIDTH-1:0]             rsp_rdata_o,
    output logic                         rsp_err_o,
    output logic                         psel_o,
    output logic                         penable_o,
    output logic                         pwrite_o,
    output logic [ADDR_WIDTH-1:0]        paddr_o,
    output logic [WIDTH-1:0]             pwdata_o,
    input  logic [WIDTH-1:0]             prdata_i,
    input  logic                         pready_i,
    input  logic                         pslverr_i
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    apb_state_e              r_state;
    logic [IDX_W-1:0]        r_ptr;
    logic [CNT_W-1:0]        r_cnt;
    logic [NUM_REQ-1:0]      r_grant;
    logic                    r_write;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [WIDTH-1:0]        r_wdata;
    logic [WIDTH-1:0]        r_rdata;
    logic                    r_err;

    logic [NUM_REQ-1:0]      w_grant;
    logic [IDX_W-1:0]        w_idx;
    logic [IDX_W-1:0]        w_nextPtr;
    logic                    w_any;
    logic [CNT_W-1:0]        w_cntNext;
    logic                    w_selWrite;
    logic [ADDR_WIDTH-1:0]   w_selAddr;
    logic [WIDTH-1:0]        w_selWdata;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .i_req   (req_valid_i),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_valid (w_any)
    );

    assign w_nextPtr = (w_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
    assign w_cntNext = r_cnt + 1'b1;

    always_comb begin
        w_selWrite = 1'b0;
        w_selAddr  = '0;
        w_selWdata = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (w_grant[j]) begin
                w_selWrite = req_write_i[j];
                w_selAddr  = req_addr_i[j*ADDR_WIDTH +: ADDR_WIDTH];
                w_selWdata = req_wdata_i[j*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge pclk_i) begin
        if (preset_i) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_grant <= '0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_grant;
                        r_write <= w_selWrite;
                        r_addr  <= w_selAddr;
                        r_wdata <= w_selWdata;
                        r_ptr   <= w_nextPtr;
                        r_state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_cnt   <= '0;
                    r_state <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // A write completes with rdata 0; a timeout aborts with rdata 0 and err 1.
                    if (pready_i) begin
                        r_rdata <= r_write ? '0 : prdata_i;
                        r_err   <= pslverr_i;
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= w_cntNext;
                        if (w_cntNext == CNT_W'(TIMEOUT)) begin
                            r_rdata <= '0;
                            r_err   <= 1'b1;
                            r_state <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    r_cnt   <= '0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign psel_o      = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
    assign penable_o   = (r_state == ST_ACCESS);
    assign pwrite_o    = psel_o & r_write;
    assign paddr_o     = psel_o ? r_addr : '0;
    assign pwdata_o    = psel_o ? r_wdata : '0;

    // Accept is combinational so the requester sees it in the same IDLE cycle.
    assign req_ready_o = ((r_state == ST_IDLE) && !preset_i) ? w_grant : '0;
    assign rsp_valid_o = (r_state == ST_RESP) ? r_grant : '0;
    assign rsp_rdata_o = (r_state == ST_RESP) ? r_rdata : '0;
    assign rsp_err_o   = (r_state == ST_RESP) ? r_err : 1'b0;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: directed scenarios plus randomized transfers checked
// against a transaction-level model of arbitration, latency and memory contents.
module tb_apb_req_arbiter;

    localparam int NUM_REQ    = 2;
    localparam int WIDTH      = 8;
    localparam int ADDR_WIDTH = 4;
    localparam int TIMEOUT    = 15;

    logic                          clock;
    logic                          reset;
    logic [NUM_REQ-1:0]            reqValid;
    logic [NUM_REQ-1:0]            reqWrite;
    logic [NUM_REQ*ADDR_WIDTH-1:0] reqAddr;
    logic [NUM_REQ*WIDTH-1:0]      reqWdata;
    logic [NUM_REQ-1:0]            reqReady;
    logic [NUM_REQ-1:0]            rspValid;
    logic [WIDTH-1:0]              rspRdata;
    logic                          rspErr;
    logic                          psel;
    logic                          penable;
    logic                          pwrite;
    logic [ADDR_WIDTH-1:0]         paddr;
    logic [WIDTH-1:0]              pwdata;
    logic [WIDTH-1:0]              prdata;
    logic                          pready;
    logic                          pslverr;

    logic                          cmdWrite [NUM_REQ];
    logic [ADDR_WIDTH-1:0]         cmdAddr  [NUM_REQ];
    logic [WIDTH-1:0]              cmdWdata [NUM_REQ];

    logic [WIDTH-1:0]              slvMem   [16];
    logic [WIDTH-1:0]              modelMem [16];
    int                            accCnt;
    int                            slvWait;
    logic                          slvErr;
    int                            rrPtr;
    int                            rspCount [NUM_REQ];
    int                            nChecks;
    int                            nFails;

    apb_req_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .pclk_i      (clock),
        .preset_i    (reset),
        .req_valid_i (reqValid),
        .req_write_i (reqWrite),
        .req_addr_i  (reqAddr),
        .req_wdata_i (reqWdata),
        .req_ready_o (reqReady),
        .rsp_valid_o (rspValid),
        .rsp_rdata_o (rspRdata),
        .rsp_err_o   (rspErr),
        .psel_o      (psel),
        .penable_o   (penable),
        .pwrite_o    (pwrite),
        .paddr_o     (paddr),
        .pwdata_o    (pwdata),
        .prdata_i    (prdata),
        .pready_i    (pready),
        .pslverr_i   (pslverr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Slave: ready after slvWait stalled ACCESS cycles; error line is driven raw in every phase.
    assign pready  = penable && (accCnt >= slvWait);
    assign prdata  = slvMem[paddr];
    assign pslverr = slvErr;

    always @(posedge clock) begin
        if (penable && !pready) accCnt <= accCnt + 1;
        else                    accCnt <= 0;
        if (psel && penable && pready && pwrite) slvMem[paddr] <= pwdata;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        assert (observed === expected) else begin
            nFails++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
            $error("[TB] %s miscompare", tag);
        end
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] valid);
        reqValid = valid;
        for (int i = 0; i < NUM_REQ; i++) begin
            reqWrite[i]                            = cmdWrite[i];
            reqAddr[i*ADDR_WIDTH +: ADDR_WIDTH]    = cmdAddr[i];
            reqWdata[i*WIDTH +: WIDTH]             = cmdWdata[i];
        end
    endtask

    function automatic int modelGrant(input logic [NUM_REQ-1:0] valid);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (valid[(rrPtr + k) % NUM_REQ]) return (rrPtr + k) % NUM_REQ;
        end
        return -1;
    endfunction

    function automatic logic [NUM_REQ-1:0] oneHot(input int g);
        logic [NUM_REQ-1:0] r;
        r = '0;
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    // One complete transfer from an IDLE negedge to the IDLE negedge after the response.
    task automatic doTransfer(input logic [NUM_REQ-1:0] valid, input bit keep,
                              input int waitStates, input bit errFlag);
        int                    g;
        int                    expCycles;
        bit                    timedOut;
        bit                    wr;
        logic [ADDR_WIDTH-1:0] ad;
        logic [WIDTH-1:0]      wd;
        logic [WIDTH-1:0]      expData;
        g         = modelGrant(valid);
        if (g < 0) g = 0;
        wr        = cmdWrite[g];
        ad        = cmdAddr[g];
        wd        = cmdWdata[g];
        timedOut  = (waitStates >= TIMEOUT);
        expCycles = timedOut ? TIMEOUT : waitStates + 1;
        expData   = (wr || timedOut) ? '0 : modelMem[ad];
        slvWait   = waitStates;
        slvErr    = errFlag;
        applyStimulus(valid);
        #1;
        checkOutput("accept_ready", reqReady, oneHot(g));
        checkOutput("accept_psel", psel, 0);
        @(negedge clock);
        if (!keep) applyStimulus('0);
        checkOutput("setup_psel", psel, 1);
        checkOutput("setup_penable", penable, 0);
        checkOutput("setup_pwrite", pwrite, wr);
        checkOutput("setup_paddr", paddr, ad);
        checkOutput("setup_pwdata", pwdata, wd);
        checkOutput("setup_ready", reqReady, 0);
        for (int k = 0; k < expCycles; k++) begin
            @(negedge clock);
            checkOutput("access_psel", psel, 1);
            checkOutput("access_penable", penable, 1);
            checkOutput("access_paddr", paddr, ad);
            checkOutput("access_rspvalid", rspValid, 0);
        end
        @(negedge clock);
        checkOutput("resp_psel", {psel, penable}, 0);
        checkOutput("resp_valid", rspValid, oneHot(g));
        checkOutput("resp_rdata", rspRdata, expData);
        checkOutput("resp_err", rspErr, timedOut || errFlag);
        for (int i = 0; i < NUM_REQ; i++) rspCount[i] += int'(rspValid[i]);
        if (wr && !timedOut) modelMem[ad] = wd;
        rrPtr = (g + 1) % NUM_REQ;
        @(negedge clock);
        slvErr = 1'b0;
        checkOutput("idle_rspvalid", rspValid, 0);
        checkOutput("idle_rsp_data_err", {rspErr, rspRdata}, 0);
        checkOutput("idle_psel", psel, 0);
    endtask

    initial begin
        logic [NUM_REQ-1:0] rv;
        int                 ws;
        int                 sel;
        nChecks = 0;
        nFails  = 0;
        rrPtr   = 0;
        slvWait = 0;
        slvErr  = 1'b0;
        accCnt  = 0;
        for (int i = 0; i < 16; i++) begin
            slvMem[i]   = WIDTH'(i * 17) ^ 8'h3C;
            modelMem[i] = WIDTH'(i * 17) ^ 8'h3C;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            cmdWrite[i] = 1'b0;
            cmdAddr[i]  = '0;
            cmdWdata[i] = '0;
            rspCount[i] = 0;
        end
        applyStimulus('0);

        $display("[TB] reset held three cycles");
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            checkOutput("reset_apb", {psel, penable}, 0);
            checkOutput("reset_rsp", {rspValid, reqReady}, 0);
        end
        reset = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            checkOutput("post_reset_apb", {psel, penable}, 0);
            checkOutput("post_reset_rsp", {rspValid, reqReady}, 0);
        end

        $display("[TB] write then read from requester 0");
        cmdWrite[0] = 1'b1; cmdAddr[0] = 4'h3; cmdWdata[0] = 8'hA5;
        doTransfer(2'b01, 1'b0, 0, 1'b0);
        cmdWrite[0] = 1'b0; cmdWdata[0] = 8'h00;
        doTransfer(2'b01, 1'b0, 0, 1'b0);

        $display("[TB] three wait states, then slave error");
        cmdWrite[1] = 1'b0; cmdAddr[1] = 4'h7;
        doTransfer(2'b10, 1'b0, 3, 1'b0);
        cmdAddr[0] = 4'h9;
        doTransfer(2'b01, 1'b0, 0, 1'b1);

        $display("[TB] timeout boundary");
        doTransfer(2'b10, 1'b0, TIMEOUT - 1, 1'b0);
        doTransfer(2'b01, 1'b0, TIMEOUT + 5, 1'b0);

        $display("[TB] reset during access");
        cmdAddr[0] = 4'h2;
        slvWait = 30;
        applyStimulus(2'b01);
        #1;
        checkOutput("abort_accept", reqReady, oneHot(modelGrant(2'b01)));
        @(negedge clock);
        applyStimulus('0);
        @(negedge clock);
        @(negedge clock);
        checkOutput("abort_in_access", {psel, penable}, 2'b11);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("abort_apb", {psel, penable}, 0);
        checkOutput("abort_rsp", {rspValid, reqReady}, 0);
        reset = 1'b0;
        rrPtr = 0;
        @(negedge clock);
        checkOutput("abort_no_rsp", rspValid, 0);
        cmdAddr[1] = 4'h3;
        doTransfer(2'b10, 1'b0, 0, 1'b0);

        $display("[TB] both requesters continuously valid");
        for (int i = 0; i < NUM_REQ; i++) begin
            rspCount[i] = 0;
            cmdWrite[i] = 1'b0;
            cmdAddr[i]  = ADDR_WIDTH'(i + 4);
        end
        for (int t = 0; t < 4; t++) doTransfer(2'b11, 1'b1, 0, 1'b0);
        applyStimulus('0);
        checkOutput("fair_count0", rspCount[0], 2);
        checkOutput("fair_count1", rspCount[1], 2);

        $display("[TB] randomized transfers");
        for (int t = 0; t < 40; t++) begin
            rv = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
            for (int i = 0; i < NUM_REQ; i++) begin
                cmdWrite[i] = 1'($urandom_range(0, 1));
                cmdAddr[i]  = ADDR_WIDTH'($urandom_range(0, 15));
                cmdWdata[i] = WIDTH'($urandom_range(0, 255));
            end
            sel = $urandom_range(0, 9);
            if (sel == 9)      ws = TIMEOUT + $urandom_range(0, 3);
            else if (sel == 8) ws = TIMEOUT - 1;
            else               ws = $urandom_range(0, 3);
            doTransfer(rv, 1'b0, ws, ($urandom_range(0, 7) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
        $finish;
    end

endmodule
